div_ctrl: RTL and testbench

Iterative 32-step restoring divider sequencer that serves the DIV/DIVU operations issued by the decode stage.
- Sits beside the EX stage. It accepts latched operands on a start handshake and holds a stall request to the pipeline control until the result is ready.
- Delivers {remainder, quotient} to EX for the HI/LO write.
- Supports an annul input, so a flushed instruction aborts the division mid-operation.

---
 rtl/div_ctrl_pkg.sv | 29 ++
 rtl/div_step.sv | 24 ++
 rtl/div_ctrl.sv | 119 +++++++++++
 tb/tb_div_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared divider definitions: FSM state codes, handshake levels and the
// ALU op codes that route an instruction to the divider.
package div_ctrl_pkg;

    localparam logic [1:0] DivFree   = 2'b00;
    localparam logic [1:0] DivByZero = 2'b01;
    localparam logic [1:0] DivOn     = 2'b10;
    localparam logic [1:0] DivEnd    = 2'b11;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    typedef enum logic [1:0] {
        DIV_FREE    = DivFree,
        DIV_BY_ZERO = DivByZero,
        DIV_ON      = DivOn,
        DIV_END     = DivEnd
    } div_state_e;

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {remainder, dividend} left by one,
// subtract the divisor when it fits and shift the quotient bit in.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] dvd_i,
    input  logic [WIDTH-1:0] dsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] dvd_o
);

    logic [WIDTH:0] upper;
    logic [WIDTH:0] diff;

    // diff[WIDTH] is the borrow: set when the shifted remainder is below the divisor
    always_comb begin
        upper = {rem_i, dvd_i[WIDTH-1]};
        diff  = upper - {1'b0, dsr_i};
        rem_o = diff[WIDTH] ? upper[WIDTH-1:0] : diff[WIDTH-1:0];
        dvd_o = {dvd_i[WIDTH-2:0], ~diff[WIDTH]};
    end

endmodule

// File: rtl/div_ctrl.sv
// Iterative restoring divider sequencer for DIV/DIVU beside the EX stage:
// accepts operands on start, stalls the pipe, returns {remainder, quotient}.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, dvd_q, dsr_q;
    logic [WIDTH-1:0] rem_nxt, dvd_nxt;
    logic             sgn_q, dvd_neg_q, dsr_neg_q;
    logic             accept, steps_done;

    function automatic logic [WIDTH-1:0] neg_if(input logic en, input logic [WIDTH-1:0] v);
        return en ? (~v + 1'b1) : v;
    endfunction

    assign accept     = (start_i == DivStart) && !annul_i;
    assign steps_done = (cnt_q == CNT_W'(WIDTH));
    assign stallreq_o = start_i & ~ready_o & ~annul_i;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .dvd_i (dvd_q),
        .dsr_i (dsr_q),
        .rem_o (rem_nxt),
        .dvd_o (dvd_nxt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_FREE:    if (accept) state_d = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
            DIV_BY_ZERO: state_d = DIV_END;
            DIV_ON: begin
                if (annul_i)         state_d = DIV_FREE;
                else if (steps_done) state_d = DIV_END;
            end
            DIV_END:     if (start_i == DivStop) state_d = DIV_FREE;
            default:     state_d = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= DIV_FREE;
        else      state_q <= state_d;
    end

    // Operands are held as magnitudes; signs are restored once all steps are done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            sgn_q     <= 1'b0;
            dvd_neg_q <= 1'b0;
            dsr_neg_q <= 1'b0;
            result_o  <= '0;
            ready_o   <= DivResultNotReady;
        end else begin
            case (state_q)
                DIV_FREE: begin
                    ready_o  <= DivResultNotReady;
                    result_o <= '0;
                    if (accept && opdata2_i != '0) begin
                        dvd_q     <= neg_if(signed_div_i & opdata1_i[WIDTH-1], opdata1_i);
                        dsr_q     <= neg_if(signed_div_i & opdata2_i[WIDTH-1], opdata2_i);
                        rem_q     <= '0;
                        sgn_q     <= signed_div_i;
                        dvd_neg_q <= opdata1_i[WIDTH-1];
                        dsr_neg_q <= opdata2_i[WIDTH-1];
                        cnt_q     <= '0;
                    end
                end
                DIV_BY_ZERO: begin
                    ready_o  <= DivResultReady;
                    result_o <= '0;
                end
                DIV_ON: begin
                    if (!annul_i) begin
                        if (!steps_done) begin
                            rem_q <= rem_nxt;
                            dvd_q <= dvd_nxt;
                            cnt_q <= cnt_q + 1'b1;
                        end else begin
                            result_o <= {neg_if(sgn_q & dvd_neg_q, rem_q),
                                         neg_if(sgn_q & (dvd_neg_q ^ dsr_neg_q), dvd_q)};
                            ready_o  <= DivResultReady;
                        end
                    end
                end
                DIV_END: begin
                    if (start_i == DivStop) begin
                        ready_o  <= DivResultNotReady;
                        result_o <= '0;
                    end
                end
                default: ready_o <= DivResultNotReady;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: directed corner cases plus random divisions compared
// against an arithmetic reference built on 64-bit integer division.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1, op2;
    logic        start, annul;
    logic [63:0] result;
    logic        ready, stallreq;

    int checks   = 0;
    int failures = 0;

    div_ctrl #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready),
        .stallreq_o   (stallreq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Called about 1 time unit after a rising edge; returns at the same phase.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] exp;
        int          lat;
        logic        stall_bad;
        exp       = model(sgn, a, b);
        signed_div = sgn;
        op1       = a;
        op2       = b;
        start     = 1'b1;
        annul     = 1'b0;
        #1;
        check({tag, "_stall_req"}, 64'(stallreq), 64'd1);
        lat       = -1;
        stall_bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            op1        = $urandom;
            op2        = $urandom;
            signed_div = 1'($urandom);
            if (ready) begin
                lat = k;
                break;
            end
            if (stallreq !== 1'b1) stall_bad = 1'b1;
        end
        check({tag, "_latency"}, 64'(lat), (b == 32'd0) ? 64'd1 : 64'd33);
        check({tag, "_result"}, result, exp);
        check({tag, "_stall_during"}, 64'(stall_bad), 64'd0);
        check({tag, "_stall_done"}, 64'(stallreq), 64'd0);
        annul = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_hold"}, {63'd0, ready} ^ result, {63'd0, 1'b1} ^ exp);
        annul = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_drop"}, {63'd0, ready} | result, 64'd0);
    endtask

    initial begin
        logic        seen;
        logic        sgn;
        logic [31:0] a, b;

        rst        = 1'b0;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        op1        = '0;
        op2        = '0;
        #2;
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_stall", 64'(stallreq), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        run_div(1'b0, 32'd100, 32'd7, "divu_100_7");
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_div(1'b0, 32'd5, 32'd0, "div_by_zero");
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, "div_7_m2");

        // Annul mid-division, then a fresh request right behind it
        signed_div = 1'b0;
        op1   = 32'd1000;
        op2   = 32'd7;
        start = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (ready) seen = 1'b1;
        end
        annul = 1'b1;
        #1;
        check("annul_stall", 64'(stallreq), 64'd0);
        @(posedge clk);
        #1;
        check("annul_ready", 64'(ready | seen), 64'd0);
        run_div(1'b0, 32'd9, 32'd3, "after_annul");

        // Start together with annul in FREE must not be accepted
        start = 1'b1;
        annul = 1'b1;
        op2   = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        annul = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (ready) seen = 1'b1;
        end
        check("annul_free_no_accept", 64'(seen), 64'd0);

        for (int i = 0; i < 12; i++) begin
            sgn = 1'($urandom);
            a   = $urandom;
            case ($urandom % 4)
                0:       b = $urandom % 16;
                1:       b = 32'hFFFF_FFF0 | ($urandom % 16);
                default: b = $urandom;
            endcase
            run_div(sgn, a, b, $sformatf("rand%0d", i));
        end

        // Asynchronous reset in the middle of a division
        signed_div = 1'b1;
        op1   = 32'h1234_5678;
        op2   = 32'd13;
        start = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            @(posedge clk);
            #1;
        end
        #2;
        start = 1'b0;
        rst   = 1'b0;
        #1;
        check("async_rst_ready", 64'(ready), 64'd0);
        check("async_rst_result", result, 64'd0);
        check("async_rst_stall", 64'(stallreq), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (ready) seen = 1'b1;
        end
        check("post_rst_idle", 64'(seen), 64'd0);
        start = 1'b1;
        #1;
        check("post_rst_stall_hi", 64'(stallreq), 64'd1);
        start = 1'b0;
        #1;
        check("post_rst_stall_lo", 64'(stallreq), 64'd0);
        @(posedge clk);
        #1;
        run_div(1'b0, 32'hFFFF_FFFF, 32'd10, "post_rst_div");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
